// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator datapath blocks.
//   otb_state_e : output_tile_buffer controller states
//   pos_width() : bit width of a counter that covers 0..depth-1.
//                 Never less than 1, so single-entry tiles still get a real port.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } otb_state_e;

    function automatic int pos_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tile_acc_mem.sv
// Partial-sum storage for one output tile: DEPTH_p positions x Tm_p maps.
// One synchronous write port and one asynchronous read port. The read is
// combinational so the stored sum reaches the compute tile in the same cycle
// it is requested.
//   clk_i   : clock
//   we_i    : write enable; the write lands at the rising edge
//   waddr_i : position being written
//   wdata_i : Tm_p values to store
//   raddr_i : position being read
//   rdata_o : Tm_p values stored at raddr_i
module tile_acc_mem
    import cnn_pkg::*;
#(
    parameter int  Tm_p    = 1,
    parameter int  DEPTH_p = 4,
    localparam int PW      = pos_width(DEPTH_p)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  shortreal      wdata_i [Tm_p],
    input  logic [PW-1:0] raddr_i,
    output shortreal      rdata_o [Tm_p]
);

    // Contents are deliberately not reset. Each position is written during
    // pass 0 before it is ever replayed or drained.
    shortreal mem [DEPTH_p][Tm_p];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int m = 0; m < Tm_p; m++) begin
                mem[waddr_i][m] <= wdata_i[m];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < Tm_p; gi++) begin : g_rd
            assign rdata_o[gi] = mem[raddr_i][gi];
        end
    endgenerate

endmodule

// File: rtl/output_tile_buffer.sv
// Output-tile accumulator that sits behind output_loop. It stores the Tm_p
// partial sums for every pixel position of the tile. On each input-channel
// pass it replays those sums as fm_init_o. After the last pass it drains the
// finished tile over a valid/ready stream.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   start_i        : begin a tile (sampled only in IDLE)
//   busy_o         : tile in progress (ACCUM or DRAIN)
//   pos_o          : position the compute tile handles this cycle
//   fm_init_o      : stored partial sums for pos_o (0.0 on the first pass)
//   acc_v_i, fm_i  : updated sums for pos_o from output_loop
//   out_v_o, out_ready_i, out_data_o, out_last_o : drain stream
//   done_o         : one-cycle pulse in the first IDLE cycle after the drain
module output_tile_buffer
    import cnn_pkg::*;
#(
    parameter int  Tm_p     = 1,
    parameter int  DEPTH_p  = 4,
    parameter int  PASSES_p = 2,
    localparam int PW       = pos_width(DEPTH_p),
    localparam int SW       = pos_width(PASSES_p)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic [PW-1:0] pos_o,
    output shortreal      fm_init_o [Tm_p],
    input  logic          acc_v_i,
    input  shortreal      fm_i [Tm_p],
    output logic          out_v_o,
    input  logic          out_ready_i,
    output shortreal      out_data_o [Tm_p],
    output logic          out_last_o,
    output logic          done_o
);

    localparam logic [PW-1:0] POS_LAST  = PW'(DEPTH_p - 1);
    localparam logic [SW-1:0] PASS_LAST = SW'(PASSES_p - 1);

    otb_state_e    state_reg, state_next;
    logic [PW-1:0] pos_reg,   pos_next;
    logic [SW-1:0] pass_reg,  pass_next;
    logic          done_reg,  done_next;

    logic          wr_en;
    logic          pos_last;
    logic          pass_last;
    shortreal      rd_data [Tm_p];

    assign pos_last  = (pos_reg == POS_LAST);
    assign pass_last = (pass_reg == PASS_LAST);

    // Replay (ACCUM) and drain (DRAIN) both read at pos_reg. The two states
    // never overlap, so one read port serves both.
    tile_acc_mem #(
        .Tm_p    (Tm_p),
        .DEPTH_p (DEPTH_p)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (pos_reg),
        .wdata_i (fm_i),
        .raddr_i (pos_reg),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
            pos_reg   <= '0;
            pass_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            pass_reg  <= pass_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        pass_next  = pass_reg;
        done_next  = 1'b0;
        wr_en      = 1'b0;
        out_v_o    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = ACCUM;
                    pos_next   = '0;
                    pass_next  = '0;
                end
            end
            ACCUM: begin
                if (acc_v_i) begin
                    wr_en = 1'b1;
                    if (pos_last) begin
                        pos_next = '0;
                        if (pass_last) begin
                            state_next = DRAIN;
                            pass_next  = '0;
                        end else begin
                            pass_next = pass_reg + SW'(1);
                        end
                    end else begin
                        pos_next = pos_reg + PW'(1);
                    end
                end
            end
            DRAIN: begin
                out_v_o = 1'b1;
                if (out_ready_i) begin
                    if (pos_last) begin
                        state_next = IDLE;
                        pos_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        pos_next = pos_reg + PW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                pos_next   = '0;
                pass_next  = '0;
            end
        endcase
    end

    assign busy_o     = (state_reg != IDLE);
    assign pos_o      = pos_reg;
    assign out_last_o = (state_reg == DRAIN) && pos_last;
    assign done_o     = done_reg;

    // The first pass starts from zero. Later passes replay what the previous
    // pass wrote at this position.
    generate
        for (genvar gi = 0; gi < Tm_p; gi++) begin : g_out
            assign fm_init_o[gi]  = (state_reg == ACCUM && pass_reg != '0) ? rd_data[gi] : 0.0;
            assign out_data_o[gi] = (state_reg == DRAIN) ? rd_data[gi] : 0.0;
        end
    endgenerate

endmodule

// File: tb/tb_output_tile_buffer.sv
module tb_output_tile_buffer;

    localparam int TM = 2;
    localparam int DA = 4;
    localparam int PA = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: Tm=2, DEPTH=4, PASSES=2
    logic     a_start = 1'b0, a_acc_v = 1'b0, a_ready = 1'b0;
    shortreal a_fm [TM];
    logic     a_busy, a_out_v, a_out_last, a_done;
    logic [1:0] a_pos;
    shortreal a_fm_init [TM];
    shortreal a_out_data [TM];

    // Instance B: Tm=2, DEPTH=1, PASSES=1
    logic     b_start = 1'b0, b_acc_v = 1'b0, b_ready = 1'b0;
    shortreal b_fm [TM];
    logic     b_busy, b_out_v, b_out_last, b_done;
    logic [0:0] b_pos;
    shortreal b_fm_init [TM];
    shortreal b_out_data [TM];

    output_tile_buffer #(.Tm_p(TM), .DEPTH_p(DA), .PASSES_p(PA)) dut_a (
        .clk_i(clk), .reset_i(rst), .start_i(a_start), .busy_o(a_busy),
        .pos_o(a_pos), .fm_init_o(a_fm_init), .acc_v_i(a_acc_v), .fm_i(a_fm),
        .out_v_o(a_out_v), .out_ready_i(a_ready), .out_data_o(a_out_data),
        .out_last_o(a_out_last), .done_o(a_done)
    );

    output_tile_buffer #(.Tm_p(TM), .DEPTH_p(1), .PASSES_p(1)) dut_b (
        .clk_i(clk), .reset_i(rst), .start_i(b_start), .busy_o(b_busy),
        .pos_o(b_pos), .fm_init_o(b_fm_init), .acc_v_i(b_acc_v), .fm_i(b_fm),
        .out_v_o(b_out_v), .out_ready_i(b_ready), .out_data_o(b_out_data),
        .out_last_o(b_out_last), .done_o(b_done)
    );

    task automatic check_value(input string tag, input real got, input real exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %g expected %g", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for instance A. The tile is a count of accepted
    // accumulate beats and a count of drained beats. The buffer is a plain
    // array indexed by (beats mod DEPTH).
    bit       m_busy, m_drain, m_done;
    int       m_nacc, m_nout;
    shortreal m_buf [DA][TM];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_drain <= 1'b0;
            m_done  <= 1'b0;
            m_nacc  <= 0;
            m_nout  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (a_start) begin
                    m_busy  <= 1'b1;
                    m_drain <= 1'b0;
                    m_nacc  <= 0;
                    m_nout  <= 0;
                end
            end else if (!m_drain) begin
                if (a_acc_v) begin
                    for (int m = 0; m < TM; m++) m_buf[m_nacc % DA][m] <= a_fm[m];
                    m_nacc <= m_nacc + 1;
                    if (m_nacc + 1 == DA * PA) m_drain <= 1'b1;
                end
            end else if (a_ready) begin
                if (m_nout == DA - 1) begin
                    m_busy  <= 1'b0;
                    m_drain <= 1'b0;
                    m_done  <= 1'b1;
                end else begin
                    m_nout <= m_nout + 1;
                end
            end
        end
    end

    function automatic int exp_pos();
        if (!m_busy) return 0;
        if (m_drain) return m_nout;
        return m_nacc % DA;
    endfunction

    function automatic real exp_init(input int m);
        if (m_busy && !m_drain && m_nacc >= DA) return m_buf[m_nacc % DA][m];
        return 0.0;
    endfunction

    function automatic real exp_data(input int m);
        if (m_drain) return m_buf[m_nout][m];
        return 0.0;
    endfunction

    always @(negedge clk) begin
        check_value("busy", a_busy, m_busy);
        check_value("pos", a_pos, exp_pos());
        check_value("out_v", a_out_v, m_drain);
        check_value("out_last", a_out_last, m_drain && (m_nout == DA - 1));
        check_value("done", a_done, m_done);
        for (int m = 0; m < TM; m++) begin
            check_value("fm_init", a_fm_init[m], exp_init(m));
            check_value("out_data", a_out_data[m], exp_data(m));
        end
    end

    // acc_mode: 0 held, 1 alternating, 2 random
    // rdy_mode: 0 held, 1 three-cycle stall on beat 1, 2 random
    // fm_mode : 0 {p+1, 10*(p+1)}, 1 random
    task automatic run_tile(input int acc_mode, input int rdy_mode, input int fm_mode,
                            input bit started, input bit start_after);
        int cyc    = 0;
        int nvalid = 0;
        int beats  = 0;
        int stall  = 0;
        bit seen_drain = 1'b0;
        if (!started) begin
            a_start = 1'b1;
            tick();
            a_start = 1'b0;
        end
        check_value("tile_busy", a_busy, 1);
        while (m_busy && cyc < 400) begin
            if (a_out_v && !seen_drain) begin
                seen_drain = 1'b1;
                check_value("valid_before_drain", nvalid, DA * PA);
            end
            if (fm_mode == 0 && !m_drain && m_nacc == DA + 2) begin
                check_value("init_pass1_p2_m0", a_fm_init[0], 3.0);
                check_value("init_pass1_p2_m1", a_fm_init[1], 30.0);
            end
            a_start = ($urandom_range(0, 3) == 0);
            if (!m_drain) begin
                case (acc_mode)
                    0:       a_acc_v = 1'b1;
                    1:       a_acc_v = (cyc % 2 == 0);
                    default: a_acc_v = 1'($urandom_range(0, 1));
                endcase
                for (int m = 0; m < TM; m++) begin
                    if (fm_mode == 0)
                        a_fm[m] = shortreal'((m_nacc % DA + 1) * ((m == 0) ? 1 : 10));
                    else
                        a_fm[m] = shortreal'($urandom_range(0, 4000)) / 8.0;
                end
                if (a_acc_v) nvalid++;
                a_ready = 1'($urandom_range(0, 1));
            end else begin
                a_acc_v = 1'($urandom_range(0, 1));
                case (rdy_mode)
                    0: a_ready = 1'b1;
                    1: begin
                        if (m_nout == 1 && stall < 3) begin
                            a_ready = 1'b0;
                            stall++;
                        end else begin
                            a_ready = 1'b1;
                        end
                    end
                    default: a_ready = 1'($urandom_range(0, 1));
                endcase
                if (a_ready && a_out_v) beats++;
            end
            tick();
            cyc++;
        end
        if (cyc >= 400) check_value("tile_timeout", 0, 1);
        check_value("drain_seen", seen_drain, 1);
        check_value("drain_beats", beats, DA);
        check_value("done_pulse", a_done, 1);
        check_value("busy_in_done", a_busy, 0);
        a_start = start_after;
        a_acc_v = 1'b0;
        a_ready = 1'b0;
        tick();
        a_start = 1'b0;
        check_value("done_single", a_done, 0);
        check_value("busy_after_done", a_busy, start_after);
    endtask

    initial begin
        for (int m = 0; m < TM; m++) begin
            a_fm[m] = 0.0;
            b_fm[m] = 0.0;
        end
        rst = 1'b1;
        repeat (3) tick();
        check_value("rst_busy", a_busy, 0);
        check_value("rst_out_v", a_out_v, 0);
        check_value("rst_pos", a_pos, 0);
        rst = 1'b0;
        tick();

        // Held accumulate, directed data, free-flowing drain
        run_tile(0, 0, 0, 1'b0, 1'b0);
        // Drain backpressure
        run_tile(0, 1, 1, 1'b0, 1'b0);
        // Gapped accumulate
        run_tile(1, 0, 1, 1'b0, 1'b0);
        // Random tiles; the last pair restarts in the done cycle
        for (int i = 0; i < 4; i++) run_tile(2, 2, 1, 1'b0, 1'b0);
        run_tile(2, 2, 1, 1'b0, 1'b1);
        run_tile(2, 2, 1, 1'b1, 1'b0);

        // Reset in the middle of pass 1, position 2
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_acc_v = 1'b1;
        a_ready = 1'b1;
        for (int k = 0; k < DA + 2; k++) begin
            for (int m = 0; m < TM; m++) a_fm[m] = shortreal'(k + 1 + 100 * m);
            tick();
        end
        check_value("pre_rst_pos", a_pos, 2);
        rst = 1'b1;
        #1;
        check_value("mid_rst_busy", a_busy, 0);
        check_value("mid_rst_pos", a_pos, 0);
        check_value("mid_rst_init", a_fm_init[0], 0.0);
        check_value("mid_rst_out_v", a_out_v, 0);
        check_value("mid_rst_last", a_out_last, 0);
        check_value("mid_rst_data", a_out_data[1], 0.0);
        check_value("mid_rst_done", a_done, 0);
        a_acc_v = 1'b0;
        a_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check_value("restart_init_m0", a_fm_init[0], 0.0);
        check_value("restart_init_m1", a_fm_init[1], 0.0);
        run_tile(0, 0, 0, 1'b1, 1'b0);

        // Single position, single pass
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check_value("b_busy", b_busy, 1);
        check_value("b_pos", b_pos, 0);
        check_value("b_init_m0", b_fm_init[0], 0.0);
        check_value("b_init_m1", b_fm_init[1], 0.0);
        b_fm[0] = 7.2;
        b_fm[1] = 5.0;
        b_acc_v = 1'b1;
        tick();
        b_acc_v = 1'b0;
        check_value("b_out_v", b_out_v, 1);
        check_value("b_data_m0", b_out_data[0], b_fm[0]);
        check_value("b_data_m1", b_out_data[1], 5.0);
        check_value("b_last", b_out_last, 1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_value("b_done", b_done, 1);
        check_value("b_busy_done", b_busy, 0);
        check_value("b_out_v_done", b_out_v, 0);
        tick();
        check_value("b_done_clear", b_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
